uart_rx_fsm: RTL and testbench

- Receive-side controller of the UART RX path. Detects the start bit and generates the per-bit edge counter plus `data_sample_en` for the data sampling stage.
- Consumes that stage's majority-voted `sampled_bit` once per bit period. From it, the block deserializes the frame (LSB first), checks parity and the stop bit, and presents the parallel byte with a valid pulse and error flags.
- Sits between the `RX_IN` line and the downstream byte consumer, alongside the data sampling stage.

---
 rtl/uart_rx_fsm_if.sv | 32 +++
 rtl/uart_rx_fsm.sv | 117 +++++++++++
 tb/tb_uart_rx_fsm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART RX controller, its data sampling stage,
// the configuration source and the downstream byte consumer.
interface uart_rx_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [4:0]            prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  sampled_bit;
  logic                  data_sample_en;
  logic [4:0]            edge_count;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
  logic                  busy;

  // Receiver side: consumes the line, config and sampler output.
  modport slave (
    input  RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
    output data_sample_en, edge_count, P_DATA, data_valid,
           parity_error, stop_error, busy
  );

  // Environment side: drives the line, config and sampler result.
  modport master (
    output RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
    input  data_sample_en, edge_count, P_DATA, data_valid,
           parity_error, stop_error, busy
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, bit timing, LSB-first
// deserialisation, parity and stop checking, byte delivery.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fsm_if.slave  rx
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [4:0]            prescale_l;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic [4:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  bit_end;

  // Last clock of the current bit period.
  assign bit_end = (edge_cnt == (prescale_l - 5'd1));

  assign rx.edge_count = edge_cnt;

  // Frame FSM with registered outputs; all decisions taken at bit end.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is a handful of flops, not a memory, so
      // clearing it on reset is cheap and keeps a discarded frame invisible.
      state             <= IDLE;
      prescale_l        <= 5'd8;
      par_en_l          <= 1'b0;
      par_typ_l         <= 1'b0;
      edge_cnt          <= '0;
      bit_cnt           <= '0;
      shift_reg         <= '0;
      rx.data_sample_en <= 1'b0;
      rx.P_DATA         <= '0;
      rx.data_valid     <= 1'b0;
      rx.parity_error   <= 1'b0;
      rx.stop_error     <= 1'b0;
      rx.busy           <= 1'b0;
    end else begin
      // NOTE: every state register uses non-blocking assignment so all of
      // them update together from the values sampled at this edge.
      rx.data_valid <= 1'b0;
      if (state == IDLE) begin
        edge_cnt          <= '0;
        rx.data_sample_en <= 1'b0;
        if (!rx.RX_IN) begin
          state             <= START;
          prescale_l        <= (rx.prescale < 5'd8) ? 5'd8 : rx.prescale;
          par_en_l          <= rx.PAR_EN;
          par_typ_l         <= rx.PAR_TYP;
          rx.parity_error   <= 1'b0;
          rx.stop_error     <= 1'b0;
          rx.data_sample_en <= 1'b1;
          rx.busy           <= 1'b1;
        end
      end else begin
        edge_cnt <= bit_end ? 5'd0 : edge_cnt + 5'd1;
        if (bit_end) begin
          case (state)
            START: begin
              if (rx.sampled_bit) begin
                // Line went back high before mid-bit: treat as a glitch.
                state             <= IDLE;
                rx.data_sample_en <= 1'b0;
                rx.busy           <= 1'b0;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shift_reg <= {rx.sampled_bit, shift_reg[DATA_WIDTH-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                state <= par_en_l ? PARITY : STOP;
              end
            end
            PARITY: begin
              rx.parity_error <= (rx.sampled_bit != ((^shift_reg) ^ par_typ_l));
              state           <= STOP;
            end
            STOP: begin
              rx.stop_error <= ~rx.sampled_bit;
              if (!rx.parity_error && rx.sampled_bit) begin
                rx.P_DATA     <= shift_reg;
                rx.data_valid <= 1'b1;
              end
              state             <= IDLE;
              rx.data_sample_en <= 1'b0;
              rx.busy           <= 1'b0;
            end
            default: begin
              state             <= IDLE;
              rx.data_sample_en <= 1'b0;
              rx.busy           <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: directed frames, a simple mid-bit
// sampler model, expected bytes and pulse cycles queued by the stimulus.
module tb_uart_rx_fsm;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   p_cur = 8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            vcyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  uart_rx_fsm_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sampler stand-in: latch the line once, in the middle of each bit.
  always @(posedge clk) begin
    if (rst) bus.sampled_bit <= 1'b1;
    else if (bus.data_sample_en && bus.edge_count == 5'(p_cur / 2))
      bus.sampled_bit <= bus.RX_IN;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.data_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'(bus.data_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("p_data", 32'(bus.P_DATA), 32'(mon_e.data));
        check("valid_cycle", cyc, mon_e.vcyc);
        check("valid_flags", {30'd0, bus.parity_error, bus.stop_error}, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int p, input logic par_en, input logic par_typ);
    p_cur       = p;
    bus.prescale = 5'(p);
    bus.PAR_EN  = par_en;
    bus.PAR_TYP = par_typ;
  endtask

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    step(n);
  endtask

  // Drive a whole frame: start, data LSB first, optional parity, stop.
  task automatic frame(input logic [DW-1:0] data, input logic par_en,
                       input logic par_bit, input logic stop_bit);
    logic [15:0] bits;
    int          nb;
    bits = '0;
    nb   = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < DW; i++) begin bits[nb] = data[i]; nb++; end
    if (par_en) begin bits[nb] = par_bit; nb++; end
    bits[nb] = stop_bit; nb++;
    for (int i = 0; i < nb; i++) begin
      bus.RX_IN = bits[i];
      step(p_cur);
    end
    bus.RX_IN = 1'b1;
  endtask

  // Correct frame with expectation pushed before the first bit goes out.
  task automatic good_frame(input logic [DW-1:0] data);
    exp_t e;
    int   par;
    par    = bus.PAR_EN ? 1 : 0;
    e.data = data;
    e.vcyc = cyc + 1 + p_cur * (2 + DW + par);
    q.push_back(e);
    frame(data, bus.PAR_EN, (^data) ^ bus.PAR_TYP, 1'b1);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_dse"}, 32'(bus.data_sample_en), 32'd0);
    check({name, "_edge"}, 32'(bus.edge_count), 32'd0);
    check({name, "_valid"}, 32'(bus.data_valid), 32'd0);
    check({name, "_perr"}, 32'(bus.parity_error), 32'd0);
    check({name, "_serr"}, 32'(bus.stop_error), 32'd0);
    check({name, "_pdata"}, 32'(bus.P_DATA), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s;
    bus.RX_IN = 1'b1;
    cfg(8, 1'b0, 1'b0);
    rst = 1'b1;
    step(3);
    check_quiet("reset");
    rst = 1'b0;
    idle(3);

    // 1: plain frame at prescale 8.
    cfg(8, 1'b0, 1'b0);
    good_frame(8'hA5);
    idle(4);
    check("t1_drained", q.size(), 0);

    // 2a: even parity, correct parity bit.
    cfg(16, 1'b1, 1'b0);
    good_frame(8'h3C);
    idle(4);
    check("t2a_drained", q.size(), 0);

    // 2b: odd parity expected 1, parity bit sent 0.
    cfg(16, 1'b1, 1'b1);
    frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("t2b_perr", 32'(bus.parity_error), 32'd1);
    check("t2b_serr", 32'(bus.stop_error), 32'd0);
    check("t2b_pdata_kept", 32'(bus.P_DATA), 32'h3C);

    // 3: stop bit low.
    cfg(8, 1'b0, 1'b0);
    frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("t3_serr", 32'(bus.stop_error), 32'd1);
    check("t3_perr_cleared", 32'(bus.parity_error), 32'd0);
    check("t3_pdata_kept", 32'(bus.P_DATA), 32'h3C);

    // 4: two-clock glitch; also clears the old stop error at start detect.
    s = cyc;
    bus.RX_IN = 1'b0;
    step(2);
    bus.RX_IN = 1'b1;
    check("t4_busy_early", 32'(bus.busy), 32'd1);
    check("t4_serr_cleared", 32'(bus.stop_error), 32'd0);
    step(s + 8 - cyc);
    check("t4_busy_edge7", 32'(bus.busy), 32'd1);
    check("t4_edge7", 32'(bus.edge_count), 32'd7);
    step(1);
    check("t4_busy_abort", 32'(bus.busy), 32'd0);
    check("t4_dse_abort", 32'(bus.data_sample_en), 32'd0);
    check("t4_flags", {30'd0, bus.parity_error, bus.stop_error}, 32'd0);
    idle(3);

    // 5: back-to-back frames, pulses 81 cycles apart.
    cfg(8, 1'b0, 1'b0);
    begin
      exp_t e;
      s = cyc;
      e.data = 8'h01; e.vcyc = s + 81;       q.push_back(e);
      e.data = 8'hFE; e.vcyc = s + 81 + 81;  q.push_back(e);
    end
    frame(8'h01, 1'b0, 1'b0, 1'b1);
    frame(8'hFE, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("t5_drained", q.size(), 0);

    // 6: reset in the middle of data bit 4, then a clean frame.
    cfg(8, 1'b0, 1'b0);
    bus.RX_IN = 1'b0; step(8);
    bus.RX_IN = 1'b0; step(8);
    bus.RX_IN = 1'b1; step(8);
    bus.RX_IN = 1'b0; step(8);
    bus.RX_IN = 1'b1; step(8);
    bus.RX_IN = 1'b1; step(3);
    check("t6_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.RX_IN = 1'b1;
    step(1);
    check_quiet("t6_reset");
    rst = 1'b0;
    idle(2);
    good_frame(8'hC3);
    idle(4);
    check("t6_drained", q.size(), 0);
    check("t6_pdata", 32'(bus.P_DATA), 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
